// File: rtl/sub64.sv
// Registered 64-bit ripple-carry subtractor (a + ~b + 1) with carry/no-borrow flag.
// Define SUB64_OVF_EN to add the registered signed-overflow output ovf.
module sub64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             c,
`ifdef SUB64_OVF_EN
  output logic             valid_out,
  output logic             ovf
`else
  output logic             valid_out
`endif
);

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   k;

  assign nb   = ~b;
  assign k[0] = 1'b1;

  // One full-adder cell per bit; the carry ripples from bit 0 upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ nb[i] ^ k[i];
    assign k[i+1] = (a[i] & nb[i]) | (a[i] & k[i]) | (nb[i] & k[i]);
  end

  // Results only load on valid_in, so idle-cycle junk on a/b never reaches the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      c         <= 1'b0;
      valid_out <= 1'b0;
`ifdef SUB64_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        out <= s;
        c   <= k[WIDTH];
`ifdef SUB64_OVF_EN
        ovf <= k[WIDTH-1] ^ k[WIDTH];
`endif
      end
    end
  end

endmodule

// File: tb/tb_sub64.sv
// Directed self-checking bench for sub64; checks the ovf output too when SUB64_OVF_EN is defined.
module tb_sub64;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] out;
  logic        c;
  logic        valid_out;
`ifdef SUB64_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int passes = 0;

  sub64 #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .out       (out),
    .c         (c),
`ifdef SUB64_OVF_EN
    .valid_out (valid_out),
    .ovf       (ovf)
`else
    .valid_out (valid_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic [63:0] va, input logic [63:0] vb, input logic vv);
    @(negedge clk);
    a        = va;
    b        = vb;
    valid_in = vv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] eo, input logic ec,
                             input logic ev);
    checks++;
    assert (out === eo) passes++;
    else $error("[TB] FAIL %s.out observed=%h expected=%h", tag, out, eo);
    checks++;
    assert (c === ec) passes++;
    else $error("[TB] FAIL %s.c observed=%b expected=%b", tag, c, ec);
    checks++;
    assert (valid_out === ev) passes++;
    else $error("[TB] FAIL %s.valid_out observed=%b expected=%b", tag, valid_out, ev);
  endtask

`ifdef SUB64_OVF_EN
  task automatic checkOvf(input string tag, input logic eov);
    checks++;
    assert (ovf === eov) passes++;
    else $error("[TB] FAIL %s.ovf observed=%b expected=%b", tag, ovf, eov);
  endtask
`endif

  initial begin
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] held_out;
    logic        held_c;

    rst      = 1'b1;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    @(posedge clk);
    #1;
    checkOutput("reset_init", 64'h0, 1'b0, 1'b0);
`ifdef SUB64_OVF_EN
    checkOvf("reset_init", 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(64'd31, 64'd63, 1'b1);
    checkOutput("first_op", 64'hFFFF_FFFF_FFFF_FFE0, 1'b0, 1'b1);

    // Back-to-back sweep with one result per cycle; all of these have a < b.
    for (int ia = 31; ia >= 16; ia--) begin
      for (int ib = 62; ib >= 47; ib--) begin
        ea = 64'(ia);
        eb = 64'(ib);
        applyStimulus(ea, eb, 1'b1);
        checkOutput($sformatf("sweep_%0d_%0d", ia, ib), ea - eb, (ea >= eb), 1'b1);
      end
    end

    applyStimulus(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);
    checkOutput("a_eq_b", 64'h0, 1'b1, 1'b1);
    applyStimulus(64'h0, 64'h1, 1'b1);
    checkOutput("zero_minus_one", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    applyStimulus(64'hDEAD_BEEF_0BAD_F00D, 64'h0, 1'b1);
    checkOutput("b_zero", 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b1);
    applyStimulus(64'h8000_0000_0000_0000, 64'h1, 1'b1);
    checkOutput("min_minus_one", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
`ifdef SUB64_OVF_EN
    checkOvf("min_minus_one", 1'b1);
`endif
    applyStimulus(64'd5, 64'd3, 1'b1);
    checkOutput("five_minus_three", 64'd2, 1'b1, 1'b1);
`ifdef SUB64_OVF_EN
    checkOvf("five_minus_three", 1'b0);
`endif
    applyStimulus(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1);
    checkOutput("borrow_chain", 64'h1, 1'b1, 1'b1);

    // Idle cycles with random and then X operands must leave out/c untouched.
    held_out = 64'h1;
    held_c   = 1'b1;
    applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    checkOutput("hold_random", held_out, held_c, 1'b0);
    applyStimulus('x, 'x, 1'b0);
    checkOutput("hold_x", held_out, held_c, 1'b0);

    // Mid-stream reset: a pending op is discarded, only the post-reset op appears.
    applyStimulus(64'd100, 64'd1, 1'b1);
    checkOutput("pre_reset_op", 64'd99, 1'b1, 1'b1);
    @(negedge clk);
    a        = 64'd50;
    b        = 64'd8;
    valid_in = 1'b1;
    rst      = 1'b1;
    #1;
    checkOutput("reset_async", 64'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_idle", 64'h0, 1'b0, 1'b0);
    applyStimulus(64'd7, 64'd2, 1'b1);
    checkOutput("post_reset_op", 64'd5, 1'b1, 1'b1);
    applyStimulus(64'd0, 64'd0, 1'b0);
    checkOutput("post_reset_drop", 64'd5, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
